// File: rtl/mul_exec_unit.sv
// Iterative shift-add multiplier for the execute stage: one multiplier bit per cycle,
// with a stall to the ID/EX register and a done pulse when the product is valid.
module mul_exec_unit #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             flush,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [3:0]       rd_in,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic [3:0]       rd_out
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e               state_q;
   logic [CntW-1:0]      cnt_q;
   logic [2*WIDTH-1:0]   mcand_q;
   logic [WIDTH-1:0]     mplier_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic                 sign_q;
   logic [3:0]           tag_q;
   logic [WIDTH-1:0]     res_lo_q;
   logic [WIDTH-1:0]     res_hi_q;
   logic [3:0]           rd_q;

   logic [WIDTH-1:0]     mag_a;
   logic [WIDTH-1:0]     mag_b;
   logic [2*WIDTH-1:0]   acc_d;
   logic [2*WIDTH-1:0]   prod_d;

   // Negating the most-negative value wraps back to itself, which read as unsigned
   // is exactly the required magnitude 2^(WIDTH-1).
   always_comb begin
      mag_a  = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
      mag_b  = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
      acc_d  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      prod_d = sign_q ? -acc_d : acc_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         sign_q   <= 1'b0;
         tag_q    <= '0;
         res_lo_q <= '0;
         res_hi_q <= '0;
         rd_q     <= '0;
      end else if (flush) begin
         state_q <= StIdle;
      end else begin
         case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  state_q  <= StRun;
                  cnt_q    <= '0;
                  mcand_q  <= {{WIDTH{1'b0}}, mag_a};
                  mplier_q <= mag_b;
                  acc_q    <= '0;
                  sign_q   <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                  tag_q    <= rd_in;
               end else begin
                  state_q <= StIdle;
               end
            end
            StRun: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 1'b1;
               // Last iteration: the final partial sum goes straight to the result.
               if (cnt_q == CntLast) begin
                  state_q  <= StDone;
                  res_lo_q <= prod_d[WIDTH-1:0];
                  res_hi_q <= prod_d[2*WIDTH-1:WIDTH];
                  rd_q     <= tag_q;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      busy      = (state_q != StIdle);
      done      = (state_q == StDone);
      stall     = (state_q == StRun) | (start & (state_q != StRun));
      result_lo = res_lo_q;
      result_hi = res_hi_q;
      rd_out    = rd_q;
   end

endmodule

// File: tb/tb_mul_exec_unit.sv
// Self-checking bench for mul_exec_unit: fixed vectors, randomized operations against an
// arithmetic reference, and hand sequences for back-to-back, mid-run start, flush and reset.
module tb_mul_exec_unit;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         reset, start, flush, is_signed;
   logic [W-1:0] op_a, op_b;
   logic [3:0]   rd_in;
   logic         busy, stall, done;
   logic [W-1:0] result_lo, result_hi;
   logic [3:0]   rd_out;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] last_prod;
   logic [3:0]  last_tag;

   mul_exec_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .flush     (flush),
      .is_signed (is_signed),
      .op_a      (op_a),
      .op_b      (op_b),
      .rd_in     (rd_in),
      .busy      (busy),
      .stall     (stall),
      .done      (done),
      .result_lo (result_lo),
      .result_hi (result_hi),
      .rd_out    (rd_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        s;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [3:0]  tag;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] ref_mul(input logic s, input logic [7:0] a,
                                            input logic [7:0] b);
      longint x, y;
      x = s ? longint'($signed(a)) : longint'({56'd0, a});
      y = s ? longint'($signed(b)) : longint'({56'd0, b});
      return 16'(x * y);
   endfunction

   // Called at a negedge with the unit idle or in DONE; returns at the negedge of DONE.
   task automatic run_op(input logic s, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] tag, input logic [15:0] exp, input string nm);
      int  k;
      bit  stall_bad;
      is_signed = s; op_a = a; op_b = b; rd_in = tag; start = 1'b1;
      #1;
      check({nm, " stall@accept"}, 32'(stall), 32'd1);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      op_a = 8'($urandom); op_b = 8'($urandom); rd_in = 4'($urandom);
      is_signed = 1'($urandom);
      stall_bad = 1'b0;
      k = 1;
      while (!done && k < 20) begin
         if (!stall || !busy) stall_bad = 1'b1;
         @(negedge clk);
         k++;
      end
      check({nm, " latency"}, 32'(k), 32'd9);
      check({nm, " stall in run"}, 32'(stall_bad), 32'd0);
      check({nm, " product"}, {16'd0, result_hi, result_lo}, {16'd0, exp});
      check({nm, " rd_out"}, 32'(rd_out), 32'(tag));
      check({nm, " stall in done"}, 32'(stall), 32'd0);
      last_prod = exp;
      last_tag  = tag;
   endtask

   task automatic check_zero(input string nm);
      check({nm, " busy"}, 32'(busy), 32'd0);
      check({nm, " stall"}, 32'(stall), 32'd0);
      check({nm, " done"}, 32'(done), 32'd0);
      check({nm, " result"}, {16'd0, result_hi, result_lo}, 32'd0);
      check({nm, " rd_out"}, 32'(rd_out), 32'd0);
   endtask

   initial begin
      int ndone;
      logic [7:0] a, b;
      logic s;
      logic [3:0] t;

      tbl[0] = '{1'b0, 8'd13, 8'd11, 4'h3, 16'h008F};
      tbl[1] = '{1'b0, 8'hFF, 8'hFF, 4'h1, 16'hFE01};
      tbl[2] = '{1'b1, 8'h80, 8'h80, 4'h2, 16'h4000};
      tbl[3] = '{1'b1, 8'hFD, 8'h05, 4'h4, 16'hFFF1};
      tbl[4] = '{1'b0, 8'hFD, 8'h05, 4'h5, 16'h04F1};
      tbl[5] = '{1'b1, 8'hFF, 8'hFF, 4'h6, 16'h0001};
      tbl[6] = '{1'b1, 8'h7F, 8'h80, 4'h7, 16'hC080};
      tbl[7] = '{1'b1, 8'h00, 8'h80, 4'hA, 16'h0000};

      reset = 1'b1; start = 1'b0; flush = 1'b0; is_signed = 1'b0;
      op_a = '0; op_b = '0; rd_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         run_op(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].tag, tbl[i].exp, $sformatf("vec%0d", i));
         @(negedge clk);
         check($sformatf("vec%0d idle", i), 32'(busy), 32'd0);
      end

      // Back-to-back: second start issued during DONE, tag 0xA.
      run_op(1'b0, 8'd13, 8'd11, 4'h3, 16'h008F, "b2b first");
      run_op(1'b1, 8'hFD, 8'h05, 4'hA, 16'hFFF1, "b2b second");
      @(negedge clk);

      for (int i = 0; i < 40; i++) begin
         s = 1'($urandom); a = 8'($urandom); b = 8'($urandom); t = 4'($urandom);
         run_op(s, a, b, t, ref_mul(s, a, b), $sformatf("rnd%0d", i));
         if ($urandom_range(1, 0) == 1) @(negedge clk);
      end
      @(negedge clk);

      // Start pulse mid-run is ignored.
      is_signed = 1'b0; op_a = 8'd13; op_b = 8'd11; rd_in = 4'h9; start = 1'b1;
      @(posedge clk);
      ndone = 0;
      for (int k = 1; k <= 22; k++) begin
         @(negedge clk);
         start = (k == 3);
         if (k == 3) begin op_a = 8'hFF; op_b = 8'hFF; rd_in = 4'h1; end
         if (done) begin
            ndone++;
            check("midstart latency", 32'(k), 32'd9);
            check("midstart product", {16'd0, result_hi, result_lo}, 32'h008F);
            check("midstart rd_out", 32'(rd_out), 32'h9);
         end
      end
      check("midstart done count", 32'(ndone), 32'd1);
      last_prod = 16'h008F; last_tag = 4'h9;

      // Flush at cycle 4 of run.
      is_signed = 1'b0; op_a = 8'h12; op_b = 8'h34; rd_in = 4'h5; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush busy", 32'(busy), 32'd0);
      check("flush done", 32'(done), 32'd0);
      check("flush result", {16'd0, result_hi, result_lo}, {16'd0, last_prod});
      check("flush rd_out", 32'(rd_out), 32'(last_tag));
      ndone = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("flush no done", 32'(ndone), 32'd0);

      // Flush overrides a simultaneous start.
      start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flush+start busy", 32'(busy), 32'd0);
      @(negedge clk);

      // Reset mid-run.
      is_signed = 1'b1; op_a = 8'h85; op_b = 8'h33; rd_in = 4'hC; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_zero("midrun reset");
      reset = 1'b0;
      @(negedge clk);

      run_op(1'b0, 8'hFF, 8'hFF, 4'hE, 16'hFE01, "post reset");
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
